tetris_input_ctrl: RTL



---
 rtl/tetris_pkg.sv | 44 ++++
 rtl/tetris_debounce.sv | 61 ++++++
 rtl/tetris_input_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// ----------------------------------------------------------------------------
// tetris_pkg
// Shared types and default constants for the Tetris input path and top level.
//   joy_state_t        : joystick direction classification
//   DEFAULT_*          : default timing (in 50 MHz cycles) and ADC thresholds
//   cycleCounterWidth  : counter width that holds the largest cycle count
// ----------------------------------------------------------------------------
package tetris_pkg;

   localparam int ADC_WIDTH = 12;

   typedef enum logic [1:0] {
      JOY_CENTER = 2'd0,
      JOY_LEFT   = 2'd1,
      JOY_RIGHT  = 2'd2
   } joy_state_t;

   // Timing defaults: 10 ms debounce, 250 ms first repeat, 100 ms repeat rate
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES      = 500000;
   localparam int unsigned DEFAULT_REPEAT_DELAY_CYCLES  = 12500000;
   localparam int unsigned DEFAULT_REPEAT_PERIOD_CYCLES = 5000000;

   // Joystick X thresholds with a hysteresis band on each side of centre
   localparam logic [ADC_WIDTH-1:0] DEFAULT_ADC_RIGHT_ON  = 12'd2106;
   localparam logic [ADC_WIDTH-1:0] DEFAULT_ADC_RIGHT_OFF = 12'd1900;
   localparam logic [ADC_WIDTH-1:0] DEFAULT_ADC_LEFT_ON   = 12'd1194;
   localparam logic [ADC_WIDTH-1:0] DEFAULT_ADC_LEFT_OFF  = 12'd1400;

   // Value the registered ADC sample takes after reset, so that a reset never
   // looks like a joystick deflection
   localparam logic [ADC_WIDTH-1:0] ADC_CENTER_VALUE = 12'd2048;

   // Width big enough for the largest of three cycle counts, with one spare bit
   function automatic int cycleCounterWidth(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/tetris_debounce.sv
// ----------------------------------------------------------------------------
// tetris_debounce
// Two-flop synchroniser plus debounce counter for one active-low pushbutton.
//   clk        : system clock
//   reset      : synchronous, active-high
//   rawButtonN : raw asynchronous button, active low
//   level      : debounced pressed level, active high (0 = released)
// The level only changes after DEBOUNCE_CYCLES consecutive cycles in which
// the synchronised input disagrees with it.
// ----------------------------------------------------------------------------
module tetris_debounce
   import tetris_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int          COUNT_WIDTH     = $clog2(DEBOUNCE_CYCLES) + 1
)(
   input  logic clk,
   input  logic reset,
   input  logic rawButtonN,
   output logic level
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                   syncMeta;
   logic                   syncOut;
   logic                   pressed;
   logic [COUNT_WIDTH-1:0] count;

   // Bring the asynchronous button into the clock domain. Both flops reset to
   // the released (high) value so a reset never fakes a press.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncMeta <= 1'b1;
         syncOut  <= 1'b1;
      end else begin
         syncMeta <= rawButtonN;
         syncOut  <= syncMeta;
      end
   end

   assign pressed = ~syncOut;

   // Count consecutive cycles of disagreement between the synchronised input
   // and the debounced level; any agreement restarts the count, so a glitch
   // shorter than the window never gets through.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         level <= 1'b0;
      end else if (pressed == level) begin
         count <= '0;
      end else if (count >= COUNT_LAST) begin
         level <= pressed;
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/tetris_input_ctrl.sv
// ----------------------------------------------------------------------------
// tetris_input_ctrl
// Turns raw buttons and the joystick ADC into single-cycle game commands.
//   clk        : system clock (50 MHz)
//   reset      : synchronous, active-high
//   s1_n       : raw rotate button, active low
//   s2_n       : raw soft-drop button, active low
//   joy_sel_n  : raw joystick select (pause), active low
//   adc_value  : free-running joystick X ADC result
//   move_left  : pulse, shift left (auto-repeats while held left)
//   move_right : pulse, shift right (auto-repeats while held right)
//   move_down  : pulse, soft drop (auto-repeats while S2 held)
//   rotate     : pulse on S1 press
//   pause      : pulse on joystick-select press
//   joy_active : level, joystick is LEFT or RIGHT
// ----------------------------------------------------------------------------
module tetris_input_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned           DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned           REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
   parameter int unsigned           REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES,
   parameter logic [ADC_WIDTH-1:0]  ADC_RIGHT_ON         = DEFAULT_ADC_RIGHT_ON,
   parameter logic [ADC_WIDTH-1:0]  ADC_RIGHT_OFF        = DEFAULT_ADC_RIGHT_OFF,
   parameter logic [ADC_WIDTH-1:0]  ADC_LEFT_ON          = DEFAULT_ADC_LEFT_ON,
   parameter logic [ADC_WIDTH-1:0]  ADC_LEFT_OFF         = DEFAULT_ADC_LEFT_OFF
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s1_n,
   input  logic                 s2_n,
   input  logic                 joy_sel_n,
   input  logic [ADC_WIDTH-1:0] adc_value,
   output logic                 move_left,
   output logic                 move_right,
   output logic                 move_down,
   output logic                 rotate,
   output logic                 pause,
   output logic                 joy_active
);

   localparam int CW = cycleCounterWidth(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                         REPEAT_PERIOD_CYCLES);
   localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);

   logic                 s1Level;
   logic                 s2Level;
   logic                 selLevel;
   logic                 s1Prev;
   logic                 selPrev;
   logic [ADC_WIDTH-1:0] adcReg;
   joy_state_t           joyState;
   joy_state_t           joyNext;
   logic [1:0]           repActive;
   logic [1:0]           repPulse;

   tetris_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNT_WIDTH(CW)) s1Debounce (
      .clk(clk), .reset(reset), .rawButtonN(s1_n), .level(s1Level)
   );

   tetris_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNT_WIDTH(CW)) s2Debounce (
      .clk(clk), .reset(reset), .rawButtonN(s2_n), .level(s2Level)
   );

   tetris_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNT_WIDTH(CW)) selDebounce (
      .clk(clk), .reset(reset), .rawButtonN(joy_sel_n), .level(selLevel)
   );

   // Rotate and pause fire once on the rising edge of their debounced level;
   // holding or releasing the button does nothing further.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1Prev  <= 1'b0;
         selPrev <= 1'b0;
         rotate  <= 1'b0;
         pause   <= 1'b0;
      end else begin
         s1Prev  <= s1Level;
         selPrev <= selLevel;
         rotate  <= s1Level & ~s1Prev;
         pause   <= selLevel & ~selPrev;
      end
   end

   // Register the free-running ADC result once before classifying it, and
   // hold the joystick direction state.
   always_ff @(posedge clk) begin
      if (reset) begin
         adcReg   <= ADC_CENTER_VALUE;
         joyState <= JOY_CENTER;
      end else begin
         adcReg   <= adc_value;
         joyState <= joyNext;
      end
   end

   // Hysteresis classifier. LEFT and RIGHT only ever return to CENTER, so a
   // direction reversal always spends at least one cycle centred, which lets
   // the repeat engine restart for the new direction.
   always_comb begin
      joyNext = joyState;
      case (joyState)
         JOY_CENTER: begin
            if (adcReg > ADC_RIGHT_ON)
               joyNext = JOY_RIGHT;
            else if (adcReg < ADC_LEFT_ON)
               joyNext = JOY_LEFT;
         end
         JOY_RIGHT: begin
            if (adcReg < ADC_RIGHT_OFF)
               joyNext = JOY_CENTER;
         end
         JOY_LEFT: begin
            if (adcReg > ADC_LEFT_OFF)
               joyNext = JOY_CENTER;
         end
         default: joyNext = JOY_CENTER;
      endcase
   end

   assign joy_active = (joyState != JOY_CENTER);
   assign repActive  = {joy_active, s2Level};

   // Auto-repeat engines: index 0 is soft drop, index 1 is joystick movement.
   // An initial pulse follows activation, the first repeat comes after the
   // long delay and later repeats at the shorter period. The output is gated
   // by the current active level so a pulse never appears in the cycle the
   // source drops away.
   for (genvar g = 0; g < 2; g++) begin : gRepeat
      logic          prevActive;
      logic          inPeriod;
      logic          pulse;
      logic [CW-1:0] cnt;

      // Repeat timer for one source; the count saturates instead of wrapping
      always_ff @(posedge clk) begin
         if (reset) begin
            prevActive <= 1'b0;
            inPeriod   <= 1'b0;
            pulse      <= 1'b0;
            cnt        <= '0;
         end else if (!repActive[g]) begin
            prevActive <= 1'b0;
            inPeriod   <= 1'b0;
            pulse      <= 1'b0;
            cnt        <= '0;
         end else if (!prevActive) begin
            prevActive <= 1'b1;
            inPeriod   <= 1'b0;
            pulse      <= 1'b1;
            cnt        <= '0;
         end else if (inPeriod ? (cnt == PERIOD_LAST) : (cnt == DELAY_LAST)) begin
            inPeriod   <= 1'b1;
            pulse      <= 1'b1;
            cnt        <= '0;
         end else begin
            pulse      <= 1'b0;
            if (cnt != '1)
               cnt <= cnt + 1'b1;
         end
      end

      assign repPulse[g] = pulse & repActive[g];
   end

   assign move_down  = repPulse[0];
   assign move_right = repPulse[1] & (joyState == JOY_RIGHT);
   assign move_left  = repPulse[1] & (joyState == JOY_LEFT);

endmodule
